serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and set the operand and result width in bits (WIDTH >= 2).
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-004 The port start SHALL be an input, 1 bit wide: request a subtraction; sampled only in IDLE.
REQ-005 The port a SHALL be an input, WIDTH bits wide: the minuend, captured on the start-accept edge.
REQ-006 The port b SHALL be an input, WIDTH bits wide: the subtrahend, captured on the start-accept edge.
REQ-007 The port busy SHALL be an output, 1 bit wide: high while in SHIFT or DONE.
REQ-008 The port done SHALL be an output, 1 bit wide: a one-cycle pulse in DONE when the result is valid.
REQ-009 The port diff SHALL be an output, WIDTH bits wide: a - b modulo 2^WIDTH.
REQ-010 The port borrow SHALL be an output, 1 bit wide: the final borrow-out, 1 iff unsigned a < b.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 In IDLE with start=1 at an edge, the block SHALL latch a and b into shift registers, clear the borrow flop, load the bit counter with 0, and enter SHIFT.
REQ-013 In SHIFT, each edge SHALL process one bit, LSB first: d = a0^b0^bin, bout = (~a0&b0)|(~(a0^b0)&bin); d shifts into the result MSB, the operands shift right, and bout is stored.
REQ-014 SHIFT SHALL last exactly WIDTH cycles, and the counter SHALL reach WIDTH-1 on the last bit, then transition to DONE.
REQ-015 In DONE, done SHALL be 1 for exactly one cycle, diff/borrow SHALL hold the final result, and the next edge SHALL return to IDLE.
REQ-016 Latency SHALL be as follows: with start accepted at edge k, done=1 in the cycle after edge k+WIDTH (WIDTH+1 cycles after accept).
REQ-017 start SHALL be ignored in SHIFT and DONE; back-to-back operation SHALL need start in the IDLE cycle following DONE.
REQ-018 Operand changes on a/b after accept SHALL NOT affect the in-flight result.
REQ-019 diff and borrow SHALL hold their last value from DONE until the next accepted start; intermediate shift contents SHALL NOT be visible on diff before DONE.
REQ-020 Arithmetic SHALL be unsigned with wrap-around: diff = (a - b) mod 2^WIDTH, with no overflow flag.

Reset
REQ-021 rst=1 at an edge SHALL force IDLE, with busy=0, done=0, diff=0, borrow=0, the counter at 0, and the borrow flop at 0, from any state including mid-SHIFT.
REQ-022 rst SHALL take priority over start when both are high, and no operation SHALL be accepted on that edge.
REQ-023 After rst deasserts, the first start SHALL be accepted in the next IDLE cycle.

Structure
REQ-024 The state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL live in a shared include/package with the other project constants.
REQ-025 The per-bit logic SHALL be a sub-module full_subtractor (inputs A, B, Bin; outputs Diff, Bout), instantiated once.
REQ-026 The top SHALL contain the FSM, the bit counter, the operand/result shift registers, and the borrow flop.

Verification
REQ-027 Scenario: a=100, b=37, start pulse -> done after 9 cycles, with diff=63 and borrow=0.
REQ-028 Scenario: a=5, b=9 -> diff=8'hFC and borrow=1; a=0, b=0 -> diff=0 and borrow=0; a=8'hFF, b=8'hFF -> diff=0 and borrow=0.
REQ-029 Scenario: a=8'h00, b=8'h01 -> diff=8'hFF and borrow=1, covering full borrow ripple across all bits.
REQ-030 Scenario: start held high and a/b changed during SHIFT -> one result only, matching the operands at accept, with a single done pulse.
REQ-031 Scenario: rst asserted at SHIFT bit 4 -> the next cycle has busy=0, diff=0, and borrow=0, with no done pulse; a new start a=20, b=3 -> diff=17.
REQ-032 Scenario: exhaustive WIDTH=3 loop over all 64 (a,b) pairs -> every diff/borrow SHALL match the reference model, with done exactly once per start.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
`timescale 1ns/1ps
// serial_subtractor_pkg
// Shared constants for the bit-serial subtractor: FSM state encoding, the
// default operand width and a helper that sizes the bit counter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bits needed for a counter that runs 0 .. w-1 (w >= 2).
  function automatic int unsigned cnt_bits(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
`timescale 1ns/1ps
// full_subtractor
// One-bit full subtractor: Diff = A - B - Bin, Bout = borrow out.
// Ports:
//   A, B  : minuend / subtrahend bits
//   Bin   : borrow in
//   Diff  : difference bit
//   Bout  : borrow out
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
// serial_subtractor
// Bit-serial unsigned subtractor. On an accepted start the operands are
// captured and processed one bit per clock, LSB first, through a single
// full_subtractor; the result and final borrow are published in DONE and
// held until the next accepted start.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request a subtraction (sampled in IDLE only)
//   a, b   : minuend / subtrahend, captured on the accept edge
//   busy   : high in SHIFT and DONE
//   done   : one-cycle pulse when diff/borrow are valid
//   diff   : (a - b) mod 2^WIDTH
//   borrow : 1 iff a < b (unsigned)
//
// state | meaning
// IDLE  | waiting for start; diff/borrow hold the last result
// SHIFT | one operand bit processed per cycle, WIDTH cycles
// DONE  | result valid, done pulses, back to IDLE next edge
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             shift_en;
  logic             last_bit;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             bflop;

  logic             d_bit;
  logic             bout_bit;

  full_subtractor u_fs (
    .A    (sa[0]),
    .B    (sb[0]),
    .Bin  (bflop),
    .Diff (d_bit),
    .Bout (bout_bit)
  );

  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The working result register res is never exposed; diff/borrow are only
  // written on the final bit so partial results never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      bflop  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (load) begin
      cnt    <= '0;
      sa     <= a;
      sb     <= b;
      res    <= '0;
      bflop  <= 1'b0;
    end else if (shift_en) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      res   <= {d_bit, res[WIDTH-1:1]};
      bflop <= bout_bit;
      if (last_bit) begin
        cnt    <= '0;
        diff   <= {d_bit, res[WIDTH-1:1]};
        borrow <= bout_bit;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start3;
  logic [7:0] a8, b8;
  logic [2:0] a3, b3;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;
  logic       busy3, done3, borrow3;
  logic [2:0] diff3;

  int tests = 0;
  int fails = 0;

  logic [7:0] prev8_d, prev3_d;
  logic       prev8_b, prev3_b;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .diff(diff3), .borrow(borrow3)
  );

  typedef struct {
    string      nm;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ed;
    logic       eb;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic, {borrow, diff}
  function automatic logic [8:0] ref_sub(input int w, input int av, input int bv);
    int mask;
    int d;
    mask = (1 << w) - 1;
    d    = (av - bv) & mask;
    return {(av < bv), 8'(d)};
  endfunction

  task automatic do_op(input bit w3, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb, input string tag);
    logic [7:0] pd, cd;
    logic       pb, cb, cdn, cbusy;
    int         n, lat;
    bit         seen, hold_ok;
    lat = w3 ? 4 : 9;
    pd  = w3 ? prev3_d : prev8_d;
    pb  = w3 ? prev3_b : prev8_b;
    @(negedge clk);
    if (w3) begin a3 = av[2:0]; b3 = bv[2:0]; start3 = 1'b1; end
    else    begin a8 = av;      b8 = bv;      start8 = 1'b1; end
    @(negedge clk);
    start3 = 1'b0; start8 = 1'b0;
    n = 1; seen = 0; hold_ok = 1;
    while (!seen && n <= 40) begin
      cdn = w3 ? done3 : done8;
      if (cdn) begin
        seen = 1;
      end else begin
        cd    = w3 ? {5'd0, diff3} : diff8;
        cb    = w3 ? borrow3 : borrow8;
        cbusy = w3 ? busy3 : busy8;
        if (cd !== pd || cb !== pb || cbusy !== 1'b1) hold_ok = 0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        a3 = 3'($urandom); b3 = 3'($urandom);
        @(negedge clk);
        n++;
      end
    end
    cd = w3 ? {5'd0, diff3} : diff8;
    cb = w3 ? borrow3 : borrow8;
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, n, lat);
    chk({tag, " diff"}, 32'(cd), 32'(ed));
    chk({tag, " borrow"}, 32'(cb), 32'(eb));
    chk({tag, " hold_busy_before_done"}, 32'(hold_ok), 32'd1);
    @(negedge clk);
    cdn   = w3 ? done3 : done8;
    cbusy = w3 ? busy3 : busy8;
    chk({tag, " single_pulse"}, {cdn, cbusy}, 32'd0);
    if (w3) begin prev3_d = ed; prev3_b = eb; end
    else    begin prev8_d = ed; prev8_b = eb; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] r;
    logic [7:0] ra, rb, cap_d;
    logic       cap_b;
    int         pulses;
    bit         extra;

    vecs[0] = '{"v100_37",  8'd100,  8'd37,  8'd63,  1'b0};
    vecs[1] = '{"v5_9",     8'd5,    8'd9,   8'hFC,  1'b1};
    vecs[2] = '{"v0_0",     8'h00,   8'h00,  8'h00,  1'b0};
    vecs[3] = '{"vFF_FF",   8'hFF,   8'hFF,  8'h00,  1'b0};
    vecs[4] = '{"v00_01",   8'h00,   8'h01,  8'hFF,  1'b1};
    vecs[5] = '{"v200_55",  8'd200,  8'd55,  8'd145, 1'b0};
    vecs[6] = '{"v1_255",   8'd1,    8'd255, 8'd2,   1'b1};
    vecs[7] = '{"v128_1",   8'd128,  8'd1,   8'd127, 1'b0};

    rst = 1'b1; start8 = 1'b0; start3 = 1'b0;
    a8 = '0; b8 = '0; a3 = '0; b3 = '0;
    prev8_d = '0; prev8_b = 1'b0; prev3_d = '0; prev3_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy8",   32'(busy8),   32'd0);
    chk("reset done8",   32'(done8),   32'd0);
    chk("reset diff8",   32'(diff8),   32'd0);
    chk("reset borrow8", 32'(borrow8), 32'd0);
    chk("reset busy3",   32'(busy3),   32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].ed, vecs[i].eb, vecs[i].nm);
    end

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      r  = ref_sub(8, int'(ra), int'(rb));
      do_op(1'b0, ra, rb, r[7:0], r[8], "rand8");
    end

    // start held high with operands changing during SHIFT
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd20; start8 = 1'b1;
    pulses = 0; cap_d = '0; cap_b = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      if (done8) begin pulses++; cap_d = diff8; cap_b = borrow8; end
    end
    start8 = 1'b0;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done8 || busy8) extra = 1;
    end
    chk("held_start pulses", pulses, 1);
    chk("held_start diff", 32'(cap_d), 32'd30);
    chk("held_start borrow", 32'(cap_b), 32'd0);
    chk("held_start no_second_op", 32'(extra), 32'd0);
    prev8_d = 8'd30; prev8_b = 1'b0;

    // reset in the middle of SHIFT, with start high on the reset edge
    @(negedge clk);
    a8 = 8'd77; b8 = 8'd11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      if (done8) extra = 1;
      @(negedge clk);
    end
    rst = 1'b1; start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
    @(negedge clk);
    chk("midrst busy",   32'(busy8),   32'd0);
    chk("midrst done",   32'(done8 | extra), 32'd0);
    chk("midrst diff",   32'(diff8),   32'd0);
    chk("midrst borrow", 32'(borrow8), 32'd0);
    rst = 1'b0; start8 = 1'b0;
    @(negedge clk);
    chk("midrst no_accept", 32'(busy8), 32'd0);
    prev8_d = '0; prev8_b = 1'b0; prev3_d = '0; prev3_b = 1'b0;
    do_op(1'b0, 8'd20, 8'd3, 8'd17, 1'b0, "after_rst");

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        r = ref_sub(3, i, j);
        do_op(1'b1, 8'(i), 8'(j), r[7:0], r[8], "exh3");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
